hazard_ctrl: RTL

//  Producer-side counterpart of the pipeline forwarding unit. Detects hazards

---
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard detection and stall/flush control
module hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1ID,
    input  logic [4:0]       Rs2ID,
    input  logic             UsesRs1,
    input  logic             UsesRs2,
    input  logic [4:0]       EXRd,
    input  logic             MemReadEX,
    input  logic             BranchTakenEX,
    input  logic             DMemReq,
    input  logic             DMemReady,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             BusError,
    output logic [CNT_W-1:0] StallCycles
);

    localparam int WC_W = $clog2(TIMEOUT + 1);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              bus_error_q, bus_error_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;

    logic load_use;
    logic mem_busy;
    logic mem_done;
    logic timed_out;

    // x0 is hardwired zero, so a load targeting it can never feed a consumer.
    assign load_use = MemReadEX && (EXRd != 5'd0) &&
                      ((UsesRs1 && (EXRd == Rs1ID)) || (UsesRs2 && (EXRd == Rs2ID)));
    assign mem_busy  = DMemReq && !DMemReady;
    // A withdrawn request ends the wait just like a completion.
    assign mem_done  = DMemReady || !DMemReq;
    assign timed_out = (wait_cnt_q == WC_W'(TIMEOUT));

    // Next-state and same-cycle stall/flush decode; everything is held low during reset.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        bus_error_d = 1'b0;
        StallF      = 1'b0;
        StallD      = 1'b0;
        StallE      = 1'b0;
        StallM      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        FlushW      = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (mem_busy) begin
                        StallF     = 1'b1;
                        StallD     = 1'b1;
                        StallE     = 1'b1;
                        StallM     = 1'b1;
                        FlushW     = 1'b1;
                        state_d    = MEM_WAIT;
                        wait_cnt_d = WC_W'(1);
                    end else if (BranchTakenEX) begin
                        // The dependent instruction in ID is discarded, so any load-use is moot.
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                    end else if (load_use) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    StallM = 1'b1;
                    FlushW = 1'b1;
                    if (mem_done) begin
                        state_d    = RUN;
                        wait_cnt_d = '0;
                    end else if (timed_out) begin
                        state_d     = RUN;
                        wait_cnt_d  = '0;
                        bus_error_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WC_W'(1);
                    end
                end
                default: begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            endcase
        end
    end

    // Saturating count of PC-hold cycles.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (StallF && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    // State, wait counter, bus-error pulse and performance counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            wait_cnt_q     <= '0;
            bus_error_q    <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            bus_error_q    <= bus_error_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign BusError    = bus_error_q;
    assign StallCycles = stall_cycles_q;

endmodule
